csd_const_mult: RTL and testbench
=================================

# csd_const_mult

Parametrised, pipelined shift-and-add constant multiplier. It computes y = a × C, where C is a sum of up to K signed power-of-two fractions held in a run-time-writable coefficient bank. It adds a valid/ready stream handshake, signed/unsigned operation, saturate/wrap selection and a per-sample overflow flag. It sits in the datapath wherever a fixed-point gain is applied, for example the 1/√2 scaling stage. Its reset coefficient is 2⁻¹+2⁻³+2⁻⁴+2⁻⁶+2⁻⁸.

## Interface
Parameters:
- W, 16: data width of `a` and `result`.
- K, 8: number of coefficient terms; power of two, 2..16.
- SIGNED, 0: 1 selects two's-complement data with arithmetic shifts; 0 selects unsigned data with logical shifts.
- SAT, 1: 1 saturates the result to the W-bit range; 0 wraps it modulo 2^W.

Ports (SW = clog2(W+1)):
- clk, input, 1: the single clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous and active-low; sampled on clk.
- a, input, W: operand.
- in_valid, input, 1: `a` is valid this cycle.
- in_ready, output, 1: the block can accept `a` this cycle.
- result, output, W: product.
- out_valid, output, 1: `result` is valid.
- out_ready, input, 1: the downstream block accepts `result`.
- out_ovf, output, 1: the result for this sample saturated (SAT=1) or wrapped (SAT=0).
- cfg_we, input, 1: write one coefficient term this cycle.
- cfg_idx, input, clog2(K): index of the term being written.
- cfg_en, input, 1: term enable.
- cfg_neg, input, 1: term sign; 1 subtracts the term.
- cfg_shift, input, SW: right-shift amount, 0..W.

## Operation
- Term i contributes t_i = en_i ? (neg_i ? −(a >> s_i) : (a >> s_i)) : 0.
- Shifts:
  - SIGNED=1: arithmetic right shift (floor).
  - SIGNED=0: logical right shift.
  - s_i = W gives 0 when unsigned, and 0 or −1 when signed.
- Sum: S = Σ t_i, computed at internal width W + clog2(K) + 1, so no internal overflow occurs.
- Output range: [0, 2^W−1] when unsigned, [−2^(W−1), 2^(W−1)−1] when signed.
- S outside the output range:
  - SAT=1: result is clamped to the nearest bound and out_ovf=1.
  - SAT=0: result is S[W−1:0] and out_ovf=1.
  - Otherwise out_ovf=0.
  - With SIGNED=0, a negative S is out of range; it clamps to 0 (SAT=1).
- Pipeline structure:
  - Stage 0 registers all K shifted/negated terms.
  - clog2(K) registered adder-tree levels follow.
  - A final stage registers the saturate/wrap logic and out_ovf.
- Each stage carries a valid bit.
- Coefficient bank:
  - Terms are read only at stage 0, so samples already in flight are unaffected by a bank write.
  - A write on cycle n applies to samples accepted on cycle n+1 and later.
  - A sample accepted on the write cycle itself uses the old value.
  - A cfg_shift value greater than W is stored as W.
- Reset values:
  - result=0, out_valid=0, out_ovf=0, all stage valid bits 0.
  - Coefficient bank: terms 0..4 enabled and positive with shifts 1, 3, 4, 6, 8 (each clamped to W); terms 5..K−1 disabled with shift 0.
- Reset during operation discards every in-flight sample, with no output for any of them, and restores the default bank. A cfg_we in the same cycle as reset is ignored.

## Timing
- Latency L = clog2(K) + 2 cycles from acceptance to out_valid, with no stall; 5 cycles for K=8.
- Throughput: one sample per cycle.
- Acceptance: a sample is accepted when in_valid && in_ready. It is retired when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready.
  - The whole pipeline freezes, including data, valid bits and out_ovf.
  - in_ready = !stall; this is combinational from registered out_valid and the out_ready input.
- Flow rules:
  - Bubbles (in_valid=0) propagate as invalid stages.
  - No sample is lost or duplicated, and output order equals input order.
- Output hold: result and out_ovf are stable while out_valid=1 and out_ready=0.
- cfg_we is accepted regardless of stall. A write during a stall applies to the first sample accepted after the write cycle.

## Test plan
Defaults W=16, K=8, SIGNED=0, SAT=1; L=5.
- Reset, then a=0x8000 with in_valid=1 for one cycle -> out_valid high exactly 5 cycles later, result=0x5A80, out_ovf=0. A following a=0xFFFF -> result=0xB4FB on the next cycle.
- Bank set to term0 {en,+,s0} and term1 {en,+,s0}, other terms disabled; a=0xC000 -> result=0xFFFF with out_ovf=1. Same bank with SAT=0 -> result=0x8000 with out_ovf=1.
- Term0 {+,s0} and term1 {−,s2}; a=100 -> result=75, out_ovf=0.
  - Swapped to term0 {+,s2} and term1 {−,s0} -> result=0, out_ovf=1.
  - SIGNED=1 instance with the swapped bank: a=100 -> result=−75 (0xFFB5); a=−1 -> result=0.
- Back-to-back stream of 0..15; hold out_ready=0 for 3 cycles starting at the first out_valid:
  - in_ready=0 during the stall.
  - result held stable during the stall.
  - All 16 outputs delivered in order, each matching the model.
- Bank write while a stream is in flight:
  - Outputs for samples accepted up to and including the write cycle use the old coefficient.
  - Outputs for samples accepted after it use the new coefficient.
- rst low for one cycle with 4 samples in flight -> out_valid=0 next cycle, none of the 4 samples appear, and the bank is back at default. The next a=0x8000 -> result=0x5A80.

Source files
------------

// File: rtl/csd_const_mult_if.sv
// Stream and coefficient-write bundle for csd_const_mult.
// master drives operands, downstream ready and bank writes; slave is the multiplier.
interface csd_const_mult_if #(
  parameter int unsigned W = 16,
  parameter int unsigned K = 8
);
  localparam int unsigned KW = $clog2(K);
  localparam int unsigned SW = $clog2(W + 1);

  logic [W-1:0]  a;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  result;
  logic          out_valid;
  logic          out_ready;
  logic          out_ovf;
  logic          cfg_we;
  logic [KW-1:0] cfg_idx;
  logic          cfg_en;
  logic          cfg_neg;
  logic [SW-1:0] cfg_shift;

  modport master (
    output a, in_valid, out_ready, cfg_we, cfg_idx, cfg_en, cfg_neg, cfg_shift,
    input  in_ready, result, out_valid, out_ovf
  );

  modport slave (
    input  a, in_valid, out_ready, cfg_we, cfg_idx, cfg_en, cfg_neg, cfg_shift,
    output in_ready, result, out_valid, out_ovf
  );
endinterface

// File: rtl/csd_const_mult.sv
// Pipelined shift-and-add constant multiplier: y = a * sum(+/- 2^-s_i) over a writable K-term bank,
// with registered term stage, registered adder tree, registered saturate/wrap stage.
module csd_const_mult #(
  parameter int unsigned W      = 16,
  parameter int unsigned K      = 8,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  csd_const_mult_if.slave bus
);

  localparam int unsigned KW = $clog2(K);
  localparam int unsigned SW = $clog2(W + 1);
  localparam int unsigned IW = W + KW + 1;
  localparam int unsigned NN = 2 * K - 1;

  localparam logic signed [IW-1:0] HI = SIGNED ? IW'({(W-1){1'b1}}) : IW'({W{1'b1}});
  localparam logic signed [IW-1:0] LO = SIGNED ? -HI - IW'(1) : IW'(0);

  function automatic logic [SW-1:0] clamp_shift(input int unsigned s);
    return (s > W) ? SW'(W) : SW'(s);
  endfunction

  function automatic int unsigned def_shift(input int unsigned i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      3:       return 6;
      4:       return 8;
      default: return 0;
    endcase
  endfunction

  logic [K-1:0]            c_en;
  logic [K-1:0]            c_neg;
  logic [SW-1:0]           c_sh [K];
  logic signed [IW-1:0]    node [NN];
  logic [KW:0]             vld;
  logic signed [IW-1:0]    a_ext_c;
  logic signed [IW-1:0]    term_c [K];
  logic                    over_c;
  logic                    under_c;
  logic                    ovf_c;
  logic [W-1:0]            res_c;
  logic                    stall_c;

  assign stall_c      = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall_c;

  // Stage-0 terms: operand widened to the tree width, then arithmetic shift (zero-fill when unsigned).
  always_comb begin
    a_ext_c = $signed({{(IW-W){SIGNED & bus.a[W-1]}}, bus.a});
    for (int i = 0; i < K; i++) begin
      term_c[i] = '0;
      if (c_en[i]) begin
        term_c[i] = c_neg[i] ? -(a_ext_c >>> c_sh[i]) : (a_ext_c >>> c_sh[i]);
      end
    end
  end

  // Range check of the tree root against the output format.
  always_comb begin
    over_c  = node[0] > HI;
    under_c = node[0] < LO;
    res_c   = node[0][W-1:0];
    if (SAT) begin
      if (over_c) begin
        res_c = HI[W-1:0];
      end else if (under_c) begin
        res_c = LO[W-1:0];
      end
    end
    ovf_c = over_c | under_c;
  end

  // Heap-ordered tree: leaves K-1..2K-2 hold terms, node n sums children 2n+1 and 2n+2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < K; i++) begin
        c_en[i]  <= (i < 5);
        c_neg[i] <= 1'b0;
        c_sh[i]  <= clamp_shift(def_shift(i));
      end
      for (int n = 0; n < NN; n++) begin
        node[n] <= '0;
      end
      vld           <= '0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      if (bus.cfg_we) begin
        c_en[bus.cfg_idx]  <= bus.cfg_en;
        c_neg[bus.cfg_idx] <= bus.cfg_neg;
        c_sh[bus.cfg_idx]  <= clamp_shift(32'(bus.cfg_shift));
      end
      if (!stall_c) begin
        for (int i = 0; i < K; i++) begin
          node[K-1+i] <= term_c[i];
        end
        for (int n = 0; n < K - 1; n++) begin
          node[n] <= node[2*n+1] + node[2*n+2];
        end
        vld[0] <= bus.in_valid;
        for (int d = 1; d <= KW; d++) begin
          vld[d] <= vld[d-1];
        end
        bus.out_valid <= vld[KW];
        bus.result    <= res_c;
        bus.out_ovf   <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_csd_const_mult.sv
// Scoreboard bench for csd_const_mult: three instances (unsigned/sat, unsigned/wrap, signed/sat)
// share one stimulus stream; a behavioural model of each fills per-instance expectation queues.
module tb_csd_const_mult;

  localparam int unsigned W = 16;
  localparam int unsigned K = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_neg = 1'b0;
  logic [4:0]  cfg_shift = '0;

  logic        ov   [3];
  logic        oovf [3];
  logic        rdy  [3];
  logic [15:0] ores [3];

  always #5 clk = ~clk;

  csd_const_mult_if #(.W(W), .K(K)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    assign bus[g].a         = a;
    assign bus[g].in_valid  = in_valid;
    assign bus[g].out_ready = out_ready;
    assign bus[g].cfg_we    = cfg_we;
    assign bus[g].cfg_idx   = cfg_idx;
    assign bus[g].cfg_en    = cfg_en;
    assign bus[g].cfg_neg   = cfg_neg;
    assign bus[g].cfg_shift = cfg_shift;
    assign ov[g]   = bus[g].out_valid;
    assign oovf[g] = bus[g].out_ovf;
    assign rdy[g]  = bus[g].in_ready;
    assign ores[g] = bus[g].result;

    csd_const_mult #(.W(W), .K(K), .SIGNED(g == 2), .SAT(g != 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ret [3] = '{0, 0, 0};
  logic [16:0] sbq  [3][$];
  logic [16:0] logq [3][$];
  bit          m_en  [8];
  bit          m_neg [8];
  int          m_sh  [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void bank_default();
    for (int i = 0; i < 8; i++) begin
      m_en[i]  = (i < 5);
      m_neg[i] = 1'b0;
    end
    m_sh[0] = 1; m_sh[1] = 3; m_sh[2] = 4; m_sh[3] = 6; m_sh[4] = 8;
    m_sh[5] = 0; m_sh[6] = 0; m_sh[7] = 0;
  endfunction

  // floor(x / 2^n) by explicit rounding toward minus infinity
  function automatic longint fdiv(input longint x, input int n);
    longint p;
    p = longint'(1) << n;
    if (x >= 0) return x / p;
    return -((-x + p - 1) / p);
  endfunction

  function automatic logic [16:0] model(input logic [15:0] av, input bit sgn, input bit sat);
    longint x, s, t, lo, hi;
    logic [15:0] r;
    bit ovf;
    x = sgn ? longint'($signed(av)) : longint'(av);
    s = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_en[i]) begin
        t = fdiv(x, m_sh[i]);
        s = m_neg[i] ? s - t : s + t;
      end
    end
    lo  = sgn ? -32768 : 0;
    hi  = sgn ? 32767 : 65535;
    ovf = (s < lo) || (s > hi);
    r   = 16'(s);
    if (ovf && sat) r = (s < lo) ? 16'(lo) : 16'(hi);
    return {ovf, r};
  endfunction

  // Retire/compare, then push new acceptances with the bank as it stood before this cycle's write.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst) begin
      for (int g = 0; g < 3; g++) sbq[g].delete();
      bank_default();
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (ov[g] && out_ready) begin
          n_ret[g]++;
          logq[g].push_back({oovf[g], ores[g]});
          if (sbq[g].size() == 0) begin
            check($sformatf("sb%0d_underrun", g), 32'(sbq[g].size()), 32'd1);
          end else begin
            e = sbq[g].pop_front();
            check($sformatf("sb%0d_out", g), 32'({oovf[g], ores[g]}), 32'(e));
          end
        end
        if (in_valid && rdy[g]) sbq[g].push_back(model(a, g == 2, g != 1));
      end
      if (cfg_we) begin
        m_en[cfg_idx]  = cfg_en;
        m_neg[cfg_idx] = cfg_neg;
        m_sh[cfg_idx]  = (cfg_shift > 5'd16) ? 16 : int'(cfg_shift);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    int guard = 0;
    a = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!rdy[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic write_term(input logic [2:0] idx, input logic en, input logic neg, input logic [4:0] sh);
    cfg_idx   = idx;
    cfg_en    = en;
    cfg_neg   = neg;
    cfg_shift = sh;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0 || sbq[2].size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) check("drain_timeout", 32'(sbq[0].size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;
    int sg;

    repeat (3) tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ovalid", 32'(ov[0]), 32'd0);
    check("rst_result", 32'(ores[0]), 32'd0);
    check("rst_ovf", 32'(oovf[0]), 32'd0);
    check("rst_iready", 32'(rdy[0]), 32'd1);
    tick();

    // latency with the default bank, then a back-to-back second sample
    a = 16'h8000;
    in_valid = 1'b1;
    tick();
    lat = 1;
    a = 16'hFFFF;
    tick();
    lat = 2;
    in_valid = 1'b0;
    while (!ov[0] && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    check("dflt_8000", 32'({oovf[0], ores[0]}), 32'({1'b0, 16'h5A80}));
    tick();
    check("dflt_next_valid", 32'(ov[0]), 32'd1);
    check("dflt_ffff", 32'({oovf[0], ores[0]}), 32'({1'b0, 16'hB4FB}));
    drain();

    // coefficient 2.0: overflow in both output modes
    write_term(3'd0, 1'b1, 1'b0, 5'd0);
    write_term(3'd1, 1'b1, 1'b0, 5'd0);
    write_term(3'd2, 1'b0, 1'b0, 5'd0);
    write_term(3'd3, 1'b0, 1'b0, 5'd0);
    write_term(3'd4, 1'b0, 1'b0, 5'd0);
    send(16'hC000);
    drain();
    check("x2_sat", 32'(logq[0][$]), 32'({1'b1, 16'hFFFF}));
    check("x2_wrap", 32'(logq[1][$]), 32'({1'b1, 16'h8000}));
    check("x2_signed", 32'(logq[2][$]), 32'({1'b0, 16'h8000}));

    // subtracting terms, then a negative coefficient
    write_term(3'd1, 1'b1, 1'b1, 5'd2);
    send(16'd100);
    drain();
    check("sub_75", 32'(logq[0][$]), 32'({1'b0, 16'd75}));
    write_term(3'd0, 1'b1, 1'b0, 5'd2);
    write_term(3'd1, 1'b1, 1'b1, 5'd0);
    send(16'd100);
    send(16'hFFFF);
    drain();
    check("neg_sat_100", 32'(logq[0][$-1]), 32'({1'b1, 16'h0000}));
    check("neg_wrap_100", 32'(logq[1][$-1]), 32'({1'b1, 16'hFFB5}));
    check("neg_signed_100", 32'(logq[2][$-1]), 32'({1'b0, 16'hFFB5}));
    check("neg_sat_ffff", 32'(logq[0][$]), 32'({1'b1, 16'h0000}));
    check("neg_wrap_ffff", 32'(logq[1][$]), 32'({1'b1, 16'h4000}));
    check("neg_signed_m1", 32'(logq[2][$]), 32'({1'b0, 16'h0000}));

    // reset with four samples in flight; a bank write in the reset cycle is dropped
    send(16'h1234);
    send(16'h8000);
    send(16'hFFFF);
    send(16'h0F0F);
    rst       = 1'b0;
    cfg_idx   = 3'd0;
    cfg_en    = 1'b0;
    cfg_neg   = 1'b1;
    cfg_shift = 5'd2;
    cfg_we    = 1'b1;
    tick();
    rst    = 1'b1;
    cfg_we = 1'b0;
    @(negedge clk);
    check("inflight_rst_ovalid", 32'(ov[0]), 32'd0);
    base = n_ret[0];
    repeat (10) tick();
    check("inflight_rst_none", 32'(n_ret[0] - base), 32'd0);
    send(16'h8000);
    drain();
    check("rst_bank_default", 32'(logq[0][$]), 32'({1'b0, 16'h5A80}));

    // stream with a three-cycle stall at the first output
    base = n_ret[0];
    fork
      begin
        for (int i = 0; i < 16; i++) send(16'(i * 16'h1111));
      end
      begin
        sg = 0;
        while (!ov[0] && sg < 40) begin
          tick();
          sg++;
        end
        if (sg >= 40) check("stall_wait", 32'(sg), 32'd0);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 32'(rdy[0]), 32'd0);
          check("stall_out_valid", 32'(ov[0]), 32'd1);
          check("stall_hold", 32'({oovf[0], ores[0]}), 32'(sbq[0][0]));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 32'(n_ret[0] - base), 32'd16);

    // bank write in the acceptance cycle of the fourth sample
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        cfg_idx   = 3'd0;
        cfg_en    = 1'b1;
        cfg_neg   = 1'b0;
        cfg_shift = 5'd31;
        cfg_we    = 1'b1;
      end
      send(16'h8000);
      cfg_we = 1'b0;
    end
    drain();
    for (int j = 0; j < 8; j++) begin
      check($sformatf("bank_swap_%0d", j), 32'(logq[0][logq[0].size() - 8 + j]),
            (j < 4) ? 32'({1'b0, 16'h5A80}) : 32'({1'b0, 16'h1A80}));
    end

    // random bank, random operands, random backpressure
    for (int i = 0; i < 8; i++) begin
      write_term(3'(i), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)));
    end
    base = n_ret[0];
    fork
      begin
        for (int i = 0; i < 40; i++) send(16'($urandom));
      end
      begin
        repeat (80) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
    check("random_count", 32'(n_ret[0] - base), 32'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
